// File: rtl/uart_hex_pkg.sv
// Shared constants, FSM encodings and hex/ASCII helpers for the UART hex command console.
package uart_hex_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic {
      RX_COLLECT = 1'b0,
      RX_HOLD    = 1'b1
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_DIGIT = 2'd1,
      TX_EOL   = 2'd2
   } tx_state_e;

   function automatic logic ascii_is_hex(input logic [7:0] c);
      return ((c >= 8'h30) && (c <= 8'h39)) ||
             ((c >= 8'h41) && (c <= 8'h46)) ||
             ((c >= 8'h61) && (c <= 8'h66));
   endfunction

   // Only meaningful when ascii_is_hex(c) is true.
   function automatic logic [3:0] ascii_to_nibble(input logic [7:0] c);
      logic [7:0] v;
      if (c <= 8'h39)
         v = c - 8'h30;
      else if (c <= 8'h46)
         v = c - 8'h37;
      else
         v = c - 8'h57;
      return v[3:0];
   endfunction

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return {4'h3, n};
      return 8'h37 + {4'h0, n};
   endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Hex digit codec: ASCII in -> nibble + is_hex, and nibble in -> uppercase ASCII.
module hex_nibble_ascii
   import uart_hex_pkg::*;
(
   input  logic [7:0] ascii_i,
   output logic [3:0] nibble_o,
   output logic       is_hex_o,
   input  logic [3:0] nibble_i,
   output logic [7:0] ascii_o
);

   assign is_hex_o = ascii_is_hex(ascii_i);
   assign nibble_o = ascii_to_nibble(ascii_i);
   assign ascii_o  = nibble_to_ascii(nibble_i);

endmodule

// File: rtl/uart_hex_cmd.sv
// Console front end: parses "<cmd><param>" hex lines from RX and prints hex responses on TX.
// Define UART_HEX_CMD_CRLF_EN to terminate printed responses with CR LF instead of CR only.
module uart_hex_cmd
   import uart_hex_pkg::*;
#(
   parameter int CMD_DIGITS   = 2,
   parameter int PARAM_DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                uart_io_rx_d,
   input  logic                      uart_io_rx_dv,
   output logic                      uart_io_rx_dr,
   output logic [4*CMD_DIGITS-1:0]   cmd,
   output logic [4*PARAM_DIGITS-1:0] param,
   output logic                      has_param,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic                      cmd_err,
   input  logic [4*PARAM_DIGITS-1:0] rsp_d,
   input  logic                      rsp_valid,
   output logic                      rsp_ready,
   output logic [7:0]                uart_io_tx_d,
   output logic                      uart_io_tx_dv,
   input  logic                      uart_io_tx_dr
);

   localparam int CW  = 4 * CMD_DIGITS;
   localparam int PW  = 4 * PARAM_DIGITS;
   localparam int TOT = CMD_DIGITS + PARAM_DIGITS;
   localparam int NW  = $clog2(TOT + 1);
   localparam int IW  = $clog2(PARAM_DIGITS + 1);

   localparam logic [NW-1:0] N_CMD  = NW'(CMD_DIGITS);
   localparam logic [NW-1:0] N_TOT  = NW'(TOT);
   localparam logic [IW-1:0] I_LAST = IW'(PARAM_DIGITS - 1);

   // ---------------- RX side ----------------
   rx_state_e      rx_state_q;
   logic [NW-1:0]  n_q;
   logic           ovf_q;
   logic [CW-1:0]  cmd_q;
   logic [PW-1:0]  param_q;
   logic           has_param_q;
   logic           cmd_err_q;

   logic [3:0]     rx_nib_d;
   logic           rx_is_hex_d;
   logic [7:0]     rx_ascii_unused;
   logic           rx_fire_d;

   hex_nibble_ascii u_rx_codec (
      .ascii_i  (uart_io_rx_d),
      .nibble_o (rx_nib_d),
      .is_hex_o (rx_is_hex_d),
      .nibble_i (4'h0),
      .ascii_o  (rx_ascii_unused)
   );

   assign rx_fire_d = uart_io_rx_dv && (rx_state_q == RX_COLLECT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q  <= RX_COLLECT;
         n_q         <= '0;
         ovf_q       <= 1'b0;
         cmd_q       <= '0;
         param_q     <= '0;
         has_param_q <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         cmd_err_q <= 1'b0;
         if ((rx_state_q == RX_HOLD) && cmd_ready)
            rx_state_q <= RX_COLLECT;
         if (rx_fire_d) begin
            if (uart_io_rx_d == ASCII_CR) begin
               n_q   <= '0;
               ovf_q <= 1'b0;
               if (n_q == N_CMD) begin
                  param_q     <= '0;
                  has_param_q <= 1'b0;
                  rx_state_q  <= RX_HOLD;
               end else if ((n_q == N_TOT) && !ovf_q) begin
                  has_param_q <= 1'b1;
                  rx_state_q  <= RX_HOLD;
               end else if (n_q != '0) begin
                  cmd_err_q <= 1'b1;
               end
            end else if (rx_is_hex_d) begin
               if (n_q == N_TOT) begin
                  ovf_q <= 1'b1;
               end else begin
                  // Digit n lands in nibble (TOT-1-n) of the concatenated {cmd, param} field.
                  for (int i = 0; i < CMD_DIGITS; i++)
                     if (n_q == NW'(CMD_DIGITS - 1 - i))
                        cmd_q[4*i +: 4] <= rx_nib_d;
                  for (int i = 0; i < PARAM_DIGITS; i++)
                     if (n_q == NW'(TOT - 1 - i))
                        param_q[4*i +: 4] <= rx_nib_d;
                  n_q <= n_q + NW'(1);
               end
            end
         end
      end
   end

   assign uart_io_rx_dr = (rx_state_q == RX_COLLECT);
   assign cmd_valid     = (rx_state_q == RX_HOLD);
   assign cmd           = cmd_q;
   assign param         = param_q;
   assign has_param     = has_param_q;
   assign cmd_err       = cmd_err_q;

   // ---------------- TX side ----------------
   tx_state_e      tx_state_q;
   logic [PW-1:0]  shift_q;
   logic [IW-1:0]  idx_q;
   logic [7:0]     tx_d_q;
   logic           tx_dv_q;
`ifdef UART_HEX_CMD_CRLF_EN
   logic           lf_q;
`endif

   logic [3:0]     tx_nib_d;
   logic [7:0]     tx_ascii_d;
   logic [3:0]     tx_nib_unused;
   logic           tx_is_hex_unused;
   logic           tx_fire_d;

   // In IDLE the first digit comes straight from rsp_d so it is ready the cycle after acceptance.
   assign tx_nib_d  = (tx_state_q == TX_IDLE) ? rsp_d[PW-1 -: 4] : shift_q[PW-1 -: 4];
   assign tx_fire_d = tx_dv_q && uart_io_tx_dr;

   hex_nibble_ascii u_tx_codec (
      .ascii_i  (8'h00),
      .nibble_o (tx_nib_unused),
      .is_hex_o (tx_is_hex_unused),
      .nibble_i (tx_nib_d),
      .ascii_o  (tx_ascii_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         shift_q    <= '0;
         idx_q      <= '0;
         tx_d_q     <= 8'h00;
         tx_dv_q    <= 1'b0;
`ifdef UART_HEX_CMD_CRLF_EN
         lf_q       <= 1'b0;
`endif
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (rsp_valid) begin
                  shift_q    <= rsp_d << 4;
                  idx_q      <= '0;
                  tx_d_q     <= tx_ascii_d;
                  tx_dv_q    <= 1'b1;
                  tx_state_q <= TX_DIGIT;
               end
            end
            TX_DIGIT: begin
               if (tx_fire_d) begin
                  if (idx_q == I_LAST) begin
                     tx_d_q     <= ASCII_CR;
                     tx_state_q <= TX_EOL;
                  end else begin
                     tx_d_q  <= tx_ascii_d;
                     shift_q <= shift_q << 4;
                     idx_q   <= idx_q + IW'(1);
                  end
               end
            end
            TX_EOL: begin
               if (tx_fire_d) begin
`ifdef UART_HEX_CMD_CRLF_EN
                  if (!lf_q) begin
                     tx_d_q <= ASCII_LF;
                     lf_q   <= 1'b1;
                  end else begin
                     lf_q       <= 1'b0;
                     tx_d_q     <= 8'h00;
                     tx_dv_q    <= 1'b0;
                     tx_state_q <= TX_IDLE;
                  end
`else
                  tx_d_q     <= 8'h00;
                  tx_dv_q    <= 1'b0;
                  tx_state_q <= TX_IDLE;
`endif
               end
            end
            default: begin
               tx_d_q     <= 8'h00;
               tx_dv_q    <= 1'b0;
               tx_state_q <= TX_IDLE;
            end
         endcase
      end
   end

   assign rsp_ready     = (tx_state_q == TX_IDLE);
   assign uart_io_tx_d  = tx_d_q;
   assign uart_io_tx_dv = tx_dv_q;

endmodule

// File: tb/tb_uart_hex_cmd.sv
// Directed bench for uart_hex_cmd: RX line parsing, TX response printing, reset behaviour.
module tb_uart_hex_cmd;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   logic        clk;
   logic        rst_n;
   logic [7:0]  uart_io_rx_d;
   logic        uart_io_rx_dv;
   logic        uart_io_rx_dr;
   logic [7:0]  cmd;
   logic [15:0] param;
   logic        has_param;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_err;
   logic [15:0] rsp_d;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  uart_io_tx_d;
   logic        uart_io_tx_dv;
   logic        uart_io_tx_dr;

   int checks = 0;
   int errors = 0;

   uart_hex_cmd #(.CMD_DIGITS(2), .PARAM_DIGITS(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .uart_io_rx_d  (uart_io_rx_d),
      .uart_io_rx_dv (uart_io_rx_dv),
      .uart_io_rx_dr (uart_io_rx_dr),
      .cmd           (cmd),
      .param         (param),
      .has_param     (has_param),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_err       (cmd_err),
      .rsp_d         (rsp_d),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .uart_io_tx_d  (uart_io_tx_d),
      .uart_io_tx_dv (uart_io_tx_dv),
      .uart_io_tx_dr (uart_io_tx_dr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Called and returns on a negedge; the transfer happens on the posedge in between.
   task automatic send_char(input logic [7:0] c);
      int t;
      uart_io_rx_d  = c;
      uart_io_rx_dv = 1'b1;
      t = 0;
      while (uart_io_rx_dr !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 100) begin
         errors++;
         $display("FAIL rx_timeout: rx_dr got %b want 1 within 100 cycles", uart_io_rx_dr);
      end
      @(negedge clk);
      uart_io_rx_dv = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++)
         send_char(s[i]);
   endtask

   task automatic ack_cmd();
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (uart_io_rx_dr !== 1'b1) begin
         errors++; $display("FAIL reset_rx_dr: got %b want 1", uart_io_rx_dr);
      end
      checks++;
      if ({cmd, param, has_param, cmd_valid, cmd_err} !== 27'd0) begin
         errors++; $display("FAIL reset_cmd_outs: got cmd=%h param=%h hp=%b v=%b err=%b want all 0",
                            cmd, param, has_param, cmd_valid, cmd_err);
      end
      checks++;
      if (rsp_ready !== 1'b1) begin
         errors++; $display("FAIL reset_rsp_ready: got %b want 1", rsp_ready);
      end
      checks++;
      if (uart_io_tx_d !== 8'h00 || uart_io_tx_dv !== 1'b0) begin
         errors++; $display("FAIL reset_tx: got d=%h dv=%b want 00/0", uart_io_tx_d, uart_io_tx_dv);
      end
      $display("reset: outputs sampled during reset");
   endtask

   task automatic test_full_cmd();
      send_str("0A1B2C");
      send_char(CR);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 8'h0A || param !== 16'h1B2C || has_param !== 1'b1) begin
         errors++; $display("FAIL full_cmd: got v=%b cmd=%h param=%h hp=%b want 1/0A/1B2C/1",
                            cmd_valid, cmd, param, has_param);
      end
      checks++;
      if (uart_io_rx_dr !== 1'b0) begin
         errors++; $display("FAIL full_cmd_rx_dr: got %b want 0", uart_io_rx_dr);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 8'h0A || param !== 16'h1B2C || has_param !== 1'b1) begin
         errors++; $display("FAIL full_cmd_hold: got v=%b cmd=%h param=%h hp=%b want 1/0A/1B2C/1",
                            cmd_valid, cmd, param, has_param);
      end
      ack_cmd();
      checks++;
      if (cmd_valid !== 1'b0 || uart_io_rx_dr !== 1'b1) begin
         errors++; $display("FAIL full_cmd_ack: got v=%b rx_dr=%b want 0/1", cmd_valid, uart_io_rx_dr);
      end
      $display("full_cmd: line 0A1B2C -> cmd=%h param=%h hp=%b", cmd, param, has_param);
   endtask

   task automatic test_short_and_err();
      send_str("f3");
      send_char(CR);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 8'hF3 || param !== 16'h0000 || has_param !== 1'b0) begin
         errors++; $display("FAIL short_cmd: got v=%b cmd=%h param=%h hp=%b want 1/F3/0000/0",
                            cmd_valid, cmd, param, has_param);
      end
      ack_cmd();
      send_str("e");
      send_char(CR);
      checks++;
      if (cmd_err !== 1'b1 || cmd_valid !== 1'b0) begin
         errors++; $display("FAIL short_err: got err=%b v=%b want 1/0", cmd_err, cmd_valid);
      end
      @(negedge clk);
      checks++;
      if (cmd_err !== 1'b0 || cmd_valid !== 1'b0) begin
         errors++; $display("FAIL short_err_pulse: got err=%b v=%b want 0/0", cmd_err, cmd_valid);
      end
      $display("short_and_err: f3 then e");
   endtask

   task automatic test_hold();
      logic hold_ok;
      send_str("0A");
      send_char(CR);
      uart_io_rx_d  = "1";
      uart_io_rx_dv = 1'b1;
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (uart_io_rx_dr !== 1'b0 || cmd_valid !== 1'b1 || cmd !== 8'h0A) hold_ok = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (hold_ok !== 1'b1) begin
         errors++; $display("FAIL hold_20: got hold_ok=%b want 1 (rx_dr low, cmd 0A held)", hold_ok);
      end
      ack_cmd();
      checks++;
      if (cmd_valid !== 1'b0 || uart_io_rx_dr !== 1'b1) begin
         errors++; $display("FAIL hold_ack: got v=%b rx_dr=%b want 0/1", cmd_valid, uart_io_rx_dr);
      end
      send_char("1");
      send_char("1");
      send_char(CR);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 8'h11 || has_param !== 1'b0) begin
         errors++; $display("FAIL hold_next: got v=%b cmd=%h hp=%b want 1/11/0", cmd_valid, cmd, has_param);
      end
      ack_cmd();
      $display("hold: 20 cycle stall then 11 -> cmd=%h", cmd);
   endtask

   task automatic test_overflow();
      send_str("12 34567");
      send_char(CR);
      checks++;
      if (cmd_err !== 1'b1 || cmd_valid !== 1'b0) begin
         errors++; $display("FAIL ovf_err: got err=%b v=%b want 1/0", cmd_err, cmd_valid);
      end
      send_char(CR);
      checks++;
      if (cmd_err !== 1'b0 || cmd_valid !== 1'b0) begin
         errors++; $display("FAIL bare_cr: got err=%b v=%b want 0/0", cmd_err, cmd_valid);
      end
      send_str("123");
      send_char(CR);
      checks++;
      if (cmd_err !== 1'b1 || cmd_valid !== 1'b0) begin
         errors++; $display("FAIL three_digit_err: got err=%b v=%b want 1/0", cmd_err, cmd_valid);
      end
      send_str("Ab\n");
      send_char(CR);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 8'hAB || has_param !== 1'b0) begin
         errors++; $display("FAIL after_err: got v=%b cmd=%h hp=%b want 1/AB/0", cmd_valid, cmd, has_param);
      end
      ack_cmd();
      $display("overflow: 7-digit line, bare CR, 3-digit line, recovery");
   endtask

   task automatic test_tx_toggle();
      logic [7:0] exp_q[$];
      logic [7:0] prev_d;
      logic       prev_hold;
      int         idx;
      exp_q = {"0", "A", "5", "F", CR};
`ifdef UART_HEX_CMD_CRLF_EN
      exp_q.push_back(LF);
`endif
      checks++;
      if (rsp_ready !== 1'b1) begin
         errors++; $display("FAIL tx_idle_ready: got %b want 1", rsp_ready);
      end
      rsp_d     = 16'h0A5F;
      rsp_valid = 1'b1;
      uart_io_tx_dr = 1'b0;
      @(negedge clk);
      rsp_valid = 1'b0;
      checks++;
      if (rsp_ready !== 1'b0 || uart_io_tx_dv !== 1'b1 || uart_io_tx_d !== 8'h30) begin
         errors++; $display("FAIL tx_first: got rdy=%b dv=%b d=%h want 0/1/30",
                            rsp_ready, uart_io_tx_dv, uart_io_tx_d);
      end
      idx = 0;
      prev_hold = 1'b0;
      prev_d = 8'h00;
      for (int cyc = 0; cyc < 60 && idx < exp_q.size(); cyc++) begin
         uart_io_tx_dr = cyc[0];
         if (prev_hold) begin
            checks++;
            if (uart_io_tx_dv !== 1'b1 || uart_io_tx_d !== prev_d) begin
               errors++; $display("FAIL tx_hold: got dv=%b d=%h want 1/%h", uart_io_tx_dv, uart_io_tx_d, prev_d);
            end
         end
         if (uart_io_tx_dv === 1'b1 && uart_io_tx_dr === 1'b1) begin
            checks++;
            if (uart_io_tx_d !== exp_q[idx]) begin
               errors++; $display("FAIL tx_char%0d: got %h want %h", idx, uart_io_tx_d, exp_q[idx]);
            end
            $display("tx: char %0d = %h", idx, uart_io_tx_d);
            idx++;
            prev_hold = 1'b0;
         end else begin
            prev_hold = uart_io_tx_dv;
            prev_d    = uart_io_tx_d;
         end
         @(negedge clk);
      end
      uart_io_tx_dr = 1'b0;
      checks++;
      if (idx != exp_q.size()) begin
         errors++; $display("FAIL tx_count: got %0d chars want %0d", idx, exp_q.size());
      end
      checks++;
      if (rsp_ready !== 1'b1 || uart_io_tx_dv !== 1'b0) begin
         errors++; $display("FAIL tx_done: got rdy=%b dv=%b want 1/0", rsp_ready, uart_io_tx_dv);
      end
   endtask

   task automatic test_concurrent();
      logic [7:0] exp_q[$];
      exp_q = {"1", "2", "3", "4", CR};
`ifdef UART_HEX_CMD_CRLF_EN
      exp_q.push_back(LF);
`endif
      send_str("5A");
      send_char(CR);
      uart_io_tx_dr = 1'b0;
      cmd_ready = 1'b1;
      rsp_d     = 16'h1234;
      rsp_valid = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      checks++;
      if (cmd_valid !== 1'b0 || uart_io_rx_dr !== 1'b1 || rsp_ready !== 1'b0 ||
          uart_io_tx_dv !== 1'b1 || uart_io_tx_d !== 8'h31) begin
         errors++; $display("FAIL concurrent: got v=%b rx_dr=%b rdy=%b dv=%b d=%h want 0/1/0/1/31",
                            cmd_valid, uart_io_rx_dr, rsp_ready, uart_io_tx_dv, uart_io_tx_d);
      end
      send_str("C3");
      send_char(CR);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 8'hC3 || uart_io_tx_d !== 8'h31) begin
         errors++; $display("FAIL rx_during_tx: got v=%b cmd=%h txd=%h want 1/C3/31", cmd_valid, cmd, uart_io_tx_d);
      end
      ack_cmd();
      uart_io_tx_dr = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (uart_io_tx_dv !== 1'b1 || uart_io_tx_d !== exp_q[i]) begin
            errors++; $display("FAIL drain_char%0d: got dv=%b d=%h want 1/%h", i, uart_io_tx_dv, uart_io_tx_d, exp_q[i]);
         end
         @(negedge clk);
      end
      uart_io_tx_dr = 1'b0;
      checks++;
      if (rsp_ready !== 1'b1 || uart_io_tx_dv !== 1'b0) begin
         errors++; $display("FAIL drain_done: got rdy=%b dv=%b want 1/0", rsp_ready, uart_io_tx_dv);
      end
      $display("concurrent: handshake + rsp in one cycle, RX line during TX");
   endtask

   task automatic test_reset_mid();
      logic quiet;
      rsp_d     = 16'h0A5F;
      rsp_valid = 1'b1;
      @(negedge clk);
      rsp_valid = 1'b0;
      uart_io_tx_dr = 1'b1;
      repeat (2) @(negedge clk);
      uart_io_tx_dr = 1'b0;
      send_str("123");
      rst_n = 1'b0;
      #1;
      checks++;
      if (uart_io_tx_dv !== 1'b0 || uart_io_tx_d !== 8'h00 || rsp_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_tx: got dv=%b d=%h rdy=%b want 0/00/1",
                            uart_io_tx_dv, uart_io_tx_d, rsp_ready);
      end
      checks++;
      if (uart_io_rx_dr !== 1'b1 || cmd !== 8'h00 || param !== 16'h0 || cmd_valid !== 1'b0 || cmd_err !== 1'b0) begin
         errors++; $display("FAIL midreset_rx: got rx_dr=%b cmd=%h param=%h v=%b err=%b want 1/00/0000/0/0",
                            uart_io_rx_dr, cmd, param, cmd_valid, cmd_err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      uart_io_tx_dr = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (uart_io_tx_dv !== 1'b0) quiet = 1'b0;
         @(negedge clk);
      end
      uart_io_tx_dr = 1'b0;
      checks++;
      if (quiet !== 1'b1) begin
         errors++; $display("FAIL midreset_stale_tx: got quiet=%b want 1", quiet);
      end
      send_str("01");
      send_char(CR);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 8'h01 || has_param !== 1'b0 || cmd_err !== 1'b0) begin
         errors++; $display("FAIL midreset_next: got v=%b cmd=%h hp=%b err=%b want 1/01/0/0",
                            cmd_valid, cmd, has_param, cmd_err);
      end
      ack_cmd();
      $display("reset_mid: partial line and response abandoned, next cmd=%h", cmd);
   endtask

   initial begin
      rst_n         = 1'b0;
      uart_io_rx_d  = 8'h00;
      uart_io_rx_dv = 1'b0;
      cmd_ready     = 1'b0;
      rsp_d         = 16'h0000;
      rsp_valid     = 1'b0;
      uart_io_tx_dr = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_full_cmd();
      test_short_and_err();
      test_hold();
      test_overflow();
      test_tx_toggle();
      test_concurrent();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
